// File: rtl/intel8237_pkg.sv
// Shared definitions for the simplified 8237A DMA controller.
//   dma_state_e : controller state, encoding is visible on the state pin
//   XFER_*      : mode-register transfer types (bits 3:2)
//   REG_*       : register offsets on a3_0 for the upper (non-channel) registers
package intel8237_pkg;

  typedef enum logic [2:0] {
    SI = 3'd0,
    S0 = 3'd1,
    S1 = 3'd2,
    S2 = 3'd3,
    S3 = 3'd4,
    S4 = 3'd5
  } dma_state_e;

  localparam logic [1:0] XFER_VERIFY = 2'b00;
  localparam logic [1:0] XFER_WRITE  = 2'b01;  // I/O -> memory
  localparam logic [1:0] XFER_READ   = 2'b10;  // memory -> I/O

  localparam logic [3:0] REG_CMD     = 4'h8;   // write: command, read: status
  localparam logic [3:0] REG_MASK1   = 4'hA;
  localparam logic [3:0] REG_MODE    = 4'hB;
  localparam logic [3:0] REG_CLRFF   = 4'hC;
  localparam logic [3:0] REG_MCLR    = 4'hD;
  localparam logic [3:0] REG_MASKALL = 4'hF;

endpackage

// File: rtl/intel8237_channel.sv
// One DMA channel: base/current address and count, mode, mask and TC flag.
// Optional feature macro INTEL8237_AUTOINIT_EN: when defined, a channel with
// mode bit4 set reloads current from base at terminal count and stays unmasked;
// otherwise it always masks itself at terminal count.
// Ports:
//   clk, reset      clock, async active-low reset
//   mclr            synchronous master clear
//   wr_addr/wr_cnt  byte write of address/count, hi_byte selects upper byte
//   wdata           write data
//   wr_mode,mode_in mode write, mode_in = {autoinit, type[1:0]}
//   mask_wr,mask_val mask update
//   step            one byte transferred: address+1, count-1
//   term            terminal count reached (internal or external EOP)
//   cur_addr/cur_cnt, xfer_type, masked, tc  channel state
module intel8237_channel
  import intel8237_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        mclr,
  input  logic        wr_addr,
  input  logic        wr_cnt,
  input  logic        hi_byte,
  input  logic [7:0]  wdata,
  input  logic        wr_mode,
  input  logic [2:0]  mode_in,
  input  logic        mask_wr,
  input  logic        mask_val,
  input  logic        step,
  input  logic        term,
  output logic [15:0] cur_addr,
  output logic [15:0] cur_cnt,
  output logic [1:0]  xfer_type,
  output logic        masked,
  output logic        tc
);

`ifdef INTEL8237_AUTOINIT_EN
  localparam bit AUTOINIT_EN = 1'b1;
`else
  localparam bit AUTOINIT_EN = 1'b0;
`endif

  logic [15:0] base_addr, base_cnt;
  logic        autoinit;
  logic        reload;

  assign reload = AUTOINIT_EN & autoinit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_addr <= '0;
      base_cnt  <= '0;
      cur_addr  <= '0;
      cur_cnt   <= '0;
      xfer_type <= XFER_VERIFY;
      autoinit  <= 1'b0;
      masked    <= 1'b0;
      tc        <= 1'b0;
    end else if (mclr) begin
      base_addr <= '0;
      base_cnt  <= '0;
      cur_addr  <= '0;
      cur_cnt   <= '0;
      xfer_type <= XFER_VERIFY;
      autoinit  <= 1'b0;
      masked    <= 1'b0;
      tc        <= 1'b0;
    end else begin
      if (wr_addr) begin
        if (hi_byte) begin
          base_addr[15:8] <= wdata;
          cur_addr[15:8]  <= wdata;
        end else begin
          base_addr[7:0]  <= wdata;
          cur_addr[7:0]   <= wdata;
        end
      end
      if (wr_cnt) begin
        if (hi_byte) begin
          base_cnt[15:8] <= wdata;
          cur_cnt[15:8]  <= wdata;
        end else begin
          base_cnt[7:0]  <= wdata;
          cur_cnt[7:0]   <= wdata;
        end
      end
      if (wr_mode) begin
        xfer_type <= mode_in[1:0];
        autoinit  <= mode_in[2];
      end
      if (mask_wr) masked <= mask_val;
      if (step) begin
        cur_addr <= cur_addr + 16'd1;
        cur_cnt  <= cur_cnt - 16'd1;
      end
      // Later assignments win: a reload overrides the step of the final byte.
      if (term) begin
        tc <= 1'b1;
        if (reload) begin
          cur_addr <= base_addr;
          cur_cnt  <= base_cnt;
        end else begin
          masked <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/intel_8237a.sv
// Simplified 4-channel 8237A DMA controller.
// Idle (SI): CPU I/O slave on cs/ior/iow/a3_0/db. On an unmasked dreq it
// raises hrq, waits for hlda, then runs one single-byte transfer S1..S4.
// Optional feature macro INTEL8237_AUTOINIT_EN (see intel8237_channel).
// Ports:
//   clk, reset (async active-low), cs, ready, hlda, dreq[3:0]
//   db, ior, iow, eopp, a3_0 : shared bidirectional bus pins
//   a7_4 : upper address nibble, Z unless master
//   hrq, dack, aen, adstb, memr, memw : bus-master controls
//   state : current controller state (SI=0 .. S4=5)
module intel_8237a
  import intel8237_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic              ready,
  input  logic              hlda,
  input  logic [NUM_CH-1:0] dreq,
  inout  wire  [7:0]        db,
  inout  wire               ior,
  inout  wire               iow,
  inout  wire               eopp,
  inout  wire  [3:0]        a3_0,
  output logic [3:0]        a7_4,
  output logic              hrq,
  output logic [NUM_CH-1:0] dack,
  output logic              aen,
  output logic              adstb,
  output logic              memr,
  output logic              memw,
  output logic [2:0]        state
);

  dma_state_e st, st_nx;
  logic [1:0] ch, ch_nx, pri;
  logic       cmd_dis, ff, rd_q;
  logic       slave, reg_wr, reg_rd, chreg, mclr;
  logic       step, term, ext_eop, tc_now;
  logic [7:0] rd_data;
  logic [15:0] word, cur_a, cur_c;
  logic [1:0] cur_t;

  logic [NUM_CH-1:0][15:0] cur_addr, cur_cnt;
  logic [NUM_CH-1:0][1:0]  xfer_type;
  logic [NUM_CH-1:0]       masked, tc, pending;

  assign slave  = (st == SI) && cs;
  assign reg_wr = slave && !iow;
  assign reg_rd = slave && !ior;
  assign chreg  = !a3_0[3];
  assign mclr   = reg_wr && (a3_0 == REG_MCLR);

  assign cur_a = cur_addr[ch];
  assign cur_c = cur_cnt[ch];
  assign cur_t = xfer_type[ch];

  assign pending = dreq & ~masked;
  assign aen     = (st != SI) && (st != S0);
  assign ext_eop = aen && !eopp;
  assign tc_now  = ext_eop || ((st == S4) && (cur_c == 16'h0000));

  // Fixed priority: channel 0 wins.
  always_comb begin
    pri = '0;
    for (int i = NUM_CH-1; i >= 0; i--)
      if (pending[i]) pri = 2'(i);
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic mask1, maskall;
    assign mask1   = reg_wr && (a3_0 == REG_MASK1) && (db[1:0] == 2'(i));
    assign maskall = reg_wr && (a3_0 == REG_MASKALL);
    intel8237_channel u_ch (
      .clk       (clk),
      .reset     (reset),
      .mclr      (mclr),
      .wr_addr   (reg_wr && chreg && !a3_0[0] && (a3_0[2:1] == 2'(i))),
      .wr_cnt    (reg_wr && chreg &&  a3_0[0] && (a3_0[2:1] == 2'(i))),
      .hi_byte   (ff),
      .wdata     (db),
      .wr_mode   (reg_wr && (a3_0 == REG_MODE) && (db[1:0] == 2'(i))),
      .mode_in   (db[4:2]),
      .mask_wr   (mask1 || maskall),
      .mask_val  (maskall ? db[i] : db[2]),
      .step      (step && (ch == 2'(i))),
      .term      (term && (ch == 2'(i))),
      .cur_addr  (cur_addr[i]),
      .cur_cnt   (cur_cnt[i]),
      .xfer_type (xfer_type[i]),
      .masked    (masked[i]),
      .tc        (tc[i])
    );
  end

  always_comb begin
    st_nx = st;
    ch_nx = ch;
    step  = 1'b0;
    term  = 1'b0;
    case (st)
      SI: if (!cmd_dis && |pending) begin
        st_nx = S0;
        ch_nx = pri;
      end
      S0: if (hlda) st_nx = S1;
      default: begin
        // Losing the bus aborts without touching the channel.
        if (!hlda) st_nx = SI;
        else if (tc_now) begin
          st_nx = SI;
          term  = 1'b1;
          step  = (st == S4);
        end else begin
          case (st)
            S1:      st_nx = S2;
            S2:      st_nx = S3;
            S3:      if (ready) st_nx = S4;
            default: begin
              st_nx = SI;
              step  = 1'b1;
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st      <= SI;
      ch      <= '0;
      cmd_dis <= 1'b0;
      ff      <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      st   <= mclr ? SI : st_nx;
      ch   <= ch_nx;
      rd_q <= reg_rd && chreg;
      if (mclr || (reg_wr && (a3_0 == REG_CLRFF))) ff <= 1'b0;
      // Reads are level-sensitive on db, so the flip-flop advances when a read ends.
      else if ((reg_wr && chreg) || (rd_q && !(reg_rd && chreg))) ff <= ~ff;
      if (mclr) cmd_dis <= 1'b0;
      else if (reg_wr && (a3_0 == REG_CMD)) cmd_dis <= db[2];
    end
  end

  always_comb begin
    rd_data = 8'h00;
    word    = 16'h0000;
    if (chreg) begin
      word    = a3_0[0] ? cur_cnt[a3_0[2:1]] : cur_addr[a3_0[2:1]];
      rd_data = ff ? word[15:8] : word[7:0];
    end else if (a3_0 == REG_CMD) begin
      rd_data = {dreq, tc};
    end
  end

  always_comb begin
    dack = '0;
    if (st == S2 || st == S3 || st == S4) dack[ch] = 1'b1;
  end

  assign hrq   = (st != SI);
  assign adstb = (st == S2);
  assign memr  = !((st == S3) && (cur_t == XFER_READ));
  assign memw  = !((st == S4) && (cur_t == XFER_WRITE));
  assign state = st;

  assign db   = (st == S2) ? cur_a[15:8] : (reg_rd ? rd_data : 8'bz);
  assign a3_0 = aen ? cur_a[3:0] : 4'bz;
  assign a7_4 = aen ? cur_a[7:4] : 4'bz;
  assign ior  = aen ? !((st == S3) && (cur_t == XFER_WRITE)) : 1'bz;
  assign iow  = aen ? !((st == S4) && (cur_t == XFER_READ)) : 1'bz;
  assign eopp = ((st == S4) && (cur_c == 16'h0000)) ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_intel_8237a.sv
// Randomized self-checking bench for intel_8237a with a transaction-level model.
module tb_intel_8237a;

`ifdef INTEL8237_AUTOINIT_EN
  localparam bit AUTO_EN = 1'b1;
`else
  localparam bit AUTO_EN = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b0, cs = 1'b0, ready = 1'b1, hlda = 1'b0;
  logic [3:0] dreq = '0;
  wire  [7:0] db;
  wire        ior, iow, eopp;
  wire  [3:0] a3_0;
  logic [3:0] a7_4, dack;
  logic       hrq, aen, adstb, memr, memw;
  logic [2:0] state;

  logic [7:0] db_o = '0;
  logic [3:0] a_o = '0;
  logic bus_oe = 1'b0, ior_o = 1'b1, iow_o = 1'b1, eop_drv = 1'b0;

  assign db   = (bus_oe && !iow_o) ? db_o : 8'bz;
  assign a3_0 = bus_oe ? a_o : 4'bz;
  assign ior  = bus_oe ? ior_o : 1'bz;
  assign iow  = bus_oe ? iow_o : 1'bz;
  assign eopp = eop_drv ? 1'b0 : 1'bz;

  for (genvar i = 0; i < 8; i++) begin : g_pu_db
    pullup (db[i]);
  end
  for (genvar i = 0; i < 4; i++) begin : g_pu_a
    pullup (a3_0[i]);
  end
  pullup (ior);
  pullup (iow);
  pullup (eopp);

  intel_8237a #(.NUM_CH(4)) dut (
    .clk(clk), .reset(reset), .cs(cs), .ready(ready), .hlda(hlda), .dreq(dreq),
    .db(db), .ior(ior), .iow(iow), .eopp(eopp), .a3_0(a3_0), .a7_4(a7_4),
    .hrq(hrq), .dack(dack), .aen(aen), .adstb(adstb), .memr(memr), .memw(memw),
    .state(state)
  );

  always #5 clk = ~clk;

  int tests = 0, errors = 0;

  // Reference model: per-channel registers as the CPU sees them.
  logic [15:0] m_addr[4], m_cnt[4], m_baddr[4], m_bcnt[4];
  logic [1:0]  m_type[4];
  logic        m_auto[4];
  logic [3:0]  m_mask, m_tc;
  logic        m_dis;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_addr[i] = '0; m_cnt[i] = '0; m_baddr[i] = '0; m_bcnt[i] = '0;
      m_type[i] = '0; m_auto[i] = 1'b0;
    end
    m_mask = '0; m_tc = '0; m_dis = 1'b0;
  endtask

  task automatic model_tc(input int c);
    m_tc[c] = 1'b1;
    if (AUTO_EN && m_auto[c]) begin
      m_addr[c] = m_baddr[c];
      m_cnt[c]  = m_bcnt[c];
    end else begin
      m_mask[c] = 1'b1;
    end
  endtask

  task automatic wr(input logic [3:0] ad, input logic [7:0] d);
    @(negedge clk);
    bus_oe = 1'b1; cs = 1'b1; a_o = ad; db_o = d; iow_o = 1'b0; ior_o = 1'b1;
    @(negedge clk);
    bus_oe = 1'b0; cs = 1'b0; iow_o = 1'b1;
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] ad, input logic [7:0] exp);
    logic [7:0] d;
    @(negedge clk);
    bus_oe = 1'b1; cs = 1'b1; a_o = ad; ior_o = 1'b0; iow_o = 1'b1;
    @(negedge clk);
    d = db;
    bus_oe = 1'b0; cs = 1'b0; ior_o = 1'b1;
    chk(tag, 32'(d), 32'(exp));
  endtask

  task automatic prog(input int c, input logic [15:0] ad, input logic [15:0] cn,
                      input logic [1:0] ty, input logic au);
    wr(4'hC, 8'h00);
    wr(4'(2*c), ad[7:0]);   wr(4'(2*c), ad[15:8]);
    wr(4'(2*c+1), cn[7:0]); wr(4'(2*c+1), cn[15:8]);
    wr(4'hB, {3'b000, au, ty, 2'(c)});
    wr(4'hA, {6'b000000, 2'(c)});
    m_addr[c] = ad; m_baddr[c] = ad; m_cnt[c] = cn; m_bcnt[c] = cn;
    m_type[c] = ty; m_auto[c] = au; m_mask[c] = 1'b0;
  endtask

  task automatic check_ch(input int c);
    wr(4'hC, 8'h00);
    rd_chk($sformatf("addr%0d_lo", c), 4'(2*c), m_addr[c][7:0]);
    rd_chk($sformatf("addr%0d_hi", c), 4'(2*c), m_addr[c][15:8]);
    rd_chk($sformatf("cnt%0d_lo", c), 4'(2*c+1), m_cnt[c][7:0]);
    rd_chk($sformatf("cnt%0d_hi", c), 4'(2*c+1), m_cnt[c][15:8]);
    rd_chk("status", 4'h8, {4'b0000, m_tc});
  endtask

  // mode: 0 = normal transfer, 1 = external EOP in S3, 2 = hlda dropped in S3
  task automatic do_xfer(input logic [3:0] req, input int waits, input int mode, input int hold);
    logic [3:0]  elig;
    logic [15:0] a;
    logic        tcx;
    int c, n;
    elig = req & ~m_mask;
    dreq = req;
    if (m_dis || elig == 4'b0000) begin
      repeat (4) @(negedge clk);
      chk("no_hrq", 32'(hrq), 0);
      chk("no_req_state", 32'(state), 0);
      dreq = '0;
      return;
    end
    c = 0;
    while (!elig[c]) c++;
    n = 0;
    do begin @(negedge clk); n++; end while (!hrq && n < 2);
    chk("hrq", 32'(hrq), 1);
    chk("s0_state", 32'(state), 1);
    if (!hrq) begin dreq = '0; return; end
    repeat (hold) begin
      @(negedge clk);
      chk("s0_hold", 32'(state), 1);
    end
    hlda = 1'b1;
    @(negedge clk);
    chk("s1_state", 32'(state), 2);
    chk("s1_aen", 32'(aen), 1);
    chk("s1_adstb", 32'(adstb), 0);
    chk("s1_dack", 32'(dack), 0);
    dreq = '0;
    a = m_addr[c];
    @(negedge clk);
    chk("s2_state", 32'(state), 3);
    chk("s2_adstb", 32'(adstb), 1);
    chk("s2_dack", 32'(dack), 32'(1) << c);
    chk("s2_alo", 32'({a7_4, a3_0}), 32'(a[7:0]));
    chk("s2_ahi", 32'(db), 32'(a[15:8]));
    ready = 1'b0;
    if (mode != 0) begin
      @(negedge clk);
      chk("s3_state", 32'(state), 4);
      if (mode == 1) eop_drv = 1'b1; else hlda = 1'b0;
      @(negedge clk);
      chk(mode == 1 ? "eop_end" : "abort_end", 32'(state), 0);
      chk("end_hrq", 32'(hrq), 0);
      chk("end_memr", 32'(memr), 1);
      eop_drv = 1'b0; hlda = 1'b0; ready = 1'b1;
      if (mode == 1) model_tc(c);
      return;
    end
    for (int k = 0; k <= waits; k++) begin
      @(negedge clk);
      chk("s3_state", 32'(state), 4);
      chk("s3_adstb", 32'(adstb), 0);
      chk("s3_memr", 32'(memr), 32'(m_type[c] != 2'b10));
      chk("s3_ior", 32'(ior), 32'(m_type[c] != 2'b01));
      ready = (k >= waits);
    end
    @(negedge clk);
    tcx = (m_cnt[c] == 16'h0000);
    chk("s4_state", 32'(state), 5);
    chk("s4_memw", 32'(memw), 32'(m_type[c] != 2'b01));
    chk("s4_iow", 32'(iow), 32'(m_type[c] != 2'b10));
    chk("s4_eop", 32'(eopp), 32'(!tcx));
    m_addr[c] = m_addr[c] + 16'd1;
    m_cnt[c]  = m_cnt[c] - 16'd1;
    if (tcx) model_tc(c);
    @(negedge clk);
    chk("end_state", 32'(state), 0);
    chk("end_hrq", 32'(hrq), 0);
    chk("end_aen", 32'(aen), 0);
    hlda = 1'b0;
  endtask

  initial begin
    int c, r, md;
    model_clear();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_state", 32'(state), 0);
    chk("rst_hrq", 32'(hrq), 0);
    chk("rst_dack", 32'(dack), 0);
    chk("rst_memr", 32'(memr), 1);
    chk("rst_memw", 32'(memw), 1);
    chk("rst_aen", 32'(aen), 0);
    chk("rst_db_z", 32'(db), 32'h00ff);

    // Count write/readback through the byte flip-flop.
    wr(4'h1, 8'h03); wr(4'h1, 8'h00);
    m_cnt[0] = 16'd3; m_bcnt[0] = 16'd3;
    rd_chk("cnt0_rb_lo", 4'h1, 8'h03);
    rd_chk("cnt0_rb_hi", 4'h1, 8'h00);

    // Read-type transfer on channel 0 with a held-off hlda.
    wr(4'hB, 8'h08); m_type[0] = 2'b10;
    do_xfer(4'b0001, 0, 0, 3);
    check_ch(0);

    // Terminal count from count 0000.
    wr(4'hC, 8'h00); wr(4'h1, 8'h00); wr(4'h1, 8'h00);
    m_cnt[0] = '0; m_bcnt[0] = '0;
    do_xfer(4'b0001, 1, 0, 0);
    check_ch(0);
    do_xfer(4'b0001, 0, 0, 0);

    // Controller disable and all-mask block requests.
    wr(4'hA, 8'h00); m_mask[0] = 1'b0;
    wr(4'h8, 8'h04); m_dis = 1'b1;
    do_xfer(4'b0001, 0, 0, 0);
    wr(4'h8, 8'h00); m_dis = 1'b0;
    wr(4'hF, 8'h0F); m_mask = 4'hF;
    do_xfer(4'b1111, 0, 0, 0);
    wr(4'hF, 8'h00); m_mask = 4'h0;

    // Priority: ch1 beats ch3.
    do_xfer(4'b1010, 0, 0, 0);
    check_ch(1);

    for (int it = 0; it < 25; it++) begin
      c = int'($urandom_range(0, 3));
      prog(c, 16'($urandom), 16'($urandom_range(0, 2)), 2'($urandom_range(0, 2)),
           1'($urandom_range(0, 1)));
      r  = int'($urandom_range(0, 9));
      md = (r == 0) ? 1 : (r == 1) ? 2 : 0;
      do_xfer(4'($urandom_range(1, 15)), int'($urandom_range(0, 2)), md,
              int'($urandom_range(0, 1)));
      for (int k = 0; k < 4; k++) check_ch(k);
    end

    // Master clear.
    wr(4'hD, 8'h00);
    model_clear();
    chk("mclr_state", 32'(state), 0);
    check_ch(0);
    check_ch(3);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
